// File: rtl/mult_div.sv
// Multicycle signed multiply/divide unit: radix-2 Booth multiply and restoring
// divide on operand magnitudes, answering each accepted start with a done pulse.
module mult_div #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        MULT,
        DIV,
        FINISH
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CW-1:0]    r_cnt;
    logic             r_op;
    logic             r_negQuo;
    logic             r_negRem;
    logic             r_qm1;
    logic [WIDTH:0]   r_hiAcc;
    logic [WIDTH-1:0] r_loAcc;
    logic [WIDTH-1:0] r_operand;

    logic             w_lastStep;
    logic             w_bZero;
    logic [WIDTH-1:0] w_absA;
    logic [WIDTH-1:0] w_absB;
    logic [WIDTH:0]   w_mcandExt;
    logic [WIDTH:0]   w_boothSum;
    logic [WIDTH:0]   w_shifted;
    logic             w_fits;
    logic [WIDTH-1:0] w_diff;

    assign w_lastStep = (r_cnt == CW'(WIDTH - 1));
    assign w_bZero    = (b == '0);
    assign w_absA     = a[WIDTH-1] ? -a : a;
    assign w_absB     = b[WIDTH-1] ? -b : b;
    assign busy       = (r_state != IDLE);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (start && !op) begin
                    w_next = MULT;
                end else if (start && op && !w_bZero) begin
                    w_next = DIV;
                end
            end
            MULT:    if (w_lastStep) w_next = FINISH;
            DIV:     if (w_lastStep) w_next = FINISH;
            FINISH:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // One extra accumulator bit keeps A +/- M exact when M is the most negative value.
    always_comb begin
        w_mcandExt = {r_operand[WIDTH-1], r_operand};
        case ({r_loAcc[0], r_qm1})
            2'b01:   w_boothSum = r_hiAcc + w_mcandExt;
            2'b10:   w_boothSum = r_hiAcc - w_mcandExt;
            default: w_boothSum = r_hiAcc;
        endcase
    end

    assign w_shifted = {r_hiAcc[WIDTH-1:0], r_loAcc[WIDTH-1]};
    assign w_fits    = (w_shifted >= {1'b0, r_operand});
    assign w_diff    = w_shifted[WIDTH-1:0] - r_operand;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt     <= '0;
            r_op      <= 1'b0;
            r_negQuo  <= 1'b0;
            r_negRem  <= 1'b0;
            r_qm1     <= 1'b0;
            r_hiAcc   <= '0;
            r_loAcc   <= '0;
            r_operand <= '0;
            hi        <= '0;
            lo        <= '0;
            done      <= 1'b0;
            div_zero  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        div_zero  <= op && w_bZero;
                        done      <= op && w_bZero;
                        r_cnt     <= '0;
                        r_op      <= op;
                        r_qm1     <= 1'b0;
                        r_hiAcc   <= '0;
                        r_negQuo  <= a[WIDTH-1] ^ b[WIDTH-1];
                        r_negRem  <= a[WIDTH-1];
                        r_loAcc   <= op ? w_absA : b;
                        r_operand <= op ? w_absB : a;
                    end
                end
                MULT: begin
                    r_hiAcc <= {w_boothSum[WIDTH], w_boothSum[WIDTH:1]};
                    r_loAcc <= {w_boothSum[0], r_loAcc[WIDTH-1:1]};
                    r_qm1   <= r_loAcc[0];
                    r_cnt   <= w_lastStep ? '0 : r_cnt + 1'b1;
                end
                DIV: begin
                    r_hiAcc <= {1'b0, (w_fits ? w_diff : w_shifted[WIDTH-1:0])};
                    r_loAcc <= {r_loAcc[WIDTH-2:0], w_fits};
                    r_cnt   <= w_lastStep ? '0 : r_cnt + 1'b1;
                end
                FINISH: begin
                    done <= 1'b1;
                    if (r_op) begin
                        lo <= r_negQuo ? -r_loAcc : r_loAcc;
                        hi <= r_negRem ? -r_hiAcc[WIDTH-1:0] : r_hiAcc[WIDTH-1:0];
                    end else begin
                        hi <= r_hiAcc[WIDTH-1:0];
                        lo <= r_loAcc;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
